// File: rtl/music_box_recorder_if.sv
// SDRAM write-command channel between the recorder (master) and the SDRAM controller (slave).
interface music_box_recorder_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned WORD_W = 16
);
    logic [ADDR_W-1:0] sdram_inputAddress;
    logic [WORD_W-1:0] sdram_writeData;
    logic              sdram_isWriting;
    logic              sdram_inputValid;
    logic              sdram_recievedCommand;
    logic              sdram_isBusy;

    modport master (
        output sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
        input  sdram_recievedCommand, sdram_isBusy
    );

    modport slave (
        input  sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid,
        output sdram_recievedCommand, sdram_isBusy
    );
endinterface

// File: rtl/music_box_recorder.sv
// Recording engine: captures SPI samples on sample_tick, packs them into SDRAM words
// and writes them through a one-word pending buffer, counting dropped words as overruns.
module music_box_recorder #(
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MAX_SAMPLES = 441000,
    parameter int unsigned STATE_ID    = 4,
    parameter int unsigned PACK_EN     = 1
) (
    input  logic                clock_50Mhz,
    input  logic                reset,
    input  logic [4:0]          mainState,
    input  logic                sample_tick,
    input  logic                stop_request,
    input  logic [SAMPLE_W-1:0] SPIinput_sample,
    music_box_recorder_if.master sdram,
    output logic                stateComplete,
    output logic [ADDR_W-1:0]   recorded_words,
    output logic [7:0]          overrun_count,
    output logic [31:0]         debugString
);
    localparam int unsigned LANES  = (PACK_EN != 0) ? WORD_W / SAMPLE_W : 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_SAMPLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        FLUSH   = 3'd2,
        DONE    = 3'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] pack_q, pack_d, data_q, data_d, word;
    logic              pending_q, pending_d, valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rec_q, rec_d;
    logic [7:0]        ovr_q, ovr_d;
    logic              active, tick_cap, lane_last, partial, word_rdy, accept;
    logic              entering, aborting, to_flush;

    assign active = (mainState == 5'(STATE_ID));

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (active) state_d = CAPTURE;
            CAPTURE: begin
                if (!active)
                    state_d = IDLE;
                else if (stop_request || (sample_tick && cnt_q == CNT_W'(MAX_SAMPLES - 1)))
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (!active)         state_d = IDLE;
                else if (!pending_q) state_d = DONE;
            end
            DONE:    if (!active) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stateComplete             = (state_q == DONE);
        sdram.sdram_inputAddress  = addr_q;
        sdram.sdram_writeData     = data_q;
        sdram.sdram_isWriting     = valid_q;
        sdram.sdram_inputValid    = valid_q;
        recorded_words            = rec_q;
        overrun_count             = ovr_q;
        debugString               = {ovr_q, 5'b0, state_q, 16'(rec_q)};
    end

    always_comb begin
        entering  = (state_q == IDLE) && (state_d == CAPTURE);
        aborting  = (state_q inside {CAPTURE, FLUSH}) && (state_d == IDLE);
        to_flush  = (state_q == CAPTURE) && (state_d == FLUSH);
        tick_cap  = (state_q == CAPTURE) && active && sample_tick;
        lane_last = (lane_q == LANE_W'(LANES - 1));
        accept    = valid_q && sdram.sdram_recievedCommand;

        word = pack_q;
        if (tick_cap) begin
            if (PACK_EN != 0) word[lane_q*SAMPLE_W +: SAMPLE_W] = SPIinput_sample;
            else              word = WORD_W'(SPIinput_sample);
        end
        // A stop leaves at most one partly filled word; it is queued on the same edge
        // as the FLUSH transition, and the cleared pack register supplies the zero padding.
        partial  = to_flush && (tick_cap ? !lane_last : (lane_q != '0));
        word_rdy = (tick_cap && lane_last) || partial;

        cnt_d     = cnt_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        data_d    = data_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        rec_d     = rec_q;
        ovr_d     = ovr_q;

        if (tick_cap) begin
            cnt_d = cnt_q + 1'b1;
            if (lane_last) begin
                lane_d = '0;
                pack_d = '0;
            end else begin
                lane_d = lane_q + 1'b1;
                pack_d = word;
            end
        end
        if (to_flush) begin
            lane_d = '0;
            pack_d = '0;
        end

        if (accept) begin
            valid_d   = 1'b0;
            pending_d = 1'b0;
            addr_d    = addr_q + 1'b1;
            rec_d     = rec_q + 1'b1;
        end else if (pending_q && !valid_q && !sdram.sdram_isBusy) begin
            valid_d = 1'b1;
        end

        if (word_rdy) begin
            if (!pending_q || accept) begin
                pending_d = 1'b1;
                data_d    = word;
            end else if (ovr_q != '1) begin
                ovr_d = ovr_q + 1'b1;
            end
        end

        if (aborting) begin
            valid_d   = 1'b0;
            pending_d = 1'b0;
        end

        if (entering) begin
            cnt_d     = '0;
            lane_d    = '0;
            pack_d    = '0;
            data_d    = '0;
            pending_d = 1'b0;
            valid_d   = 1'b0;
            addr_d    = ADDR_W'(BASE_ADDR);
            rec_d     = '0;
            ovr_d     = '0;
        end
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
            data_q    <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            rec_q     <= '0;
            ovr_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            pack_q    <= pack_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            rec_q     <= rec_d;
            ovr_q     <= ovr_d;
        end
    end
endmodule

// File: tb/tb_music_box_recorder.sv
// Directed and randomized checks of music_box_recorder against a packing/ordering model.
module tb_music_box_recorder;
    localparam int unsigned AW = 25;
    localparam int unsigned WW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    ms = '0;
    logic          tick = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    samp = '0;
    logic          complete;
    logic [AW-1:0] recw;
    logic [7:0]    ovr;
    logic [31:0]   dbg;

    music_box_recorder_if #(.ADDR_W(AW), .WORD_W(WW)) sd ();

    music_box_recorder #(.MAX_SAMPLES(6)) dut (
        .clock_50Mhz     (clk),
        .reset           (rst),
        .mainState       (ms),
        .sample_tick     (tick),
        .stop_request    (stop),
        .SPIinput_sample (samp),
        .sdram           (sd),
        .stateComplete   (complete),
        .recorded_words  (recw),
        .overrun_count   (ovr),
        .debugString     (dbg)
    );

    initial forever #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            auto_delay = 3;
    int            hold_cnt = 0;
    logic          prev_valid = 1'b0;
    logic [AW-1:0] log_a[$];
    logic [WW-1:0] log_d[$];
    logic [7:0]    s[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Little-endian packing of two samples per word, missing upper sample reads as zero.
    function automatic logic [WW-1:0] exp_word(input int k, input int n);
        logic [7:0] hi;
        hi = (2*k + 1 < n) ? s[2*k+1] : 8'h00;
        return {hi, s[2*k]};
    endfunction

    task automatic accept_now();
        log_a.push_back(sd.sdram_inputAddress);
        log_d.push_back(sd.sdram_writeData);
        sd.sdram_recievedCommand = 1'b1;
    endtask

    // One clock: drives applied before the call are seen at the rising edge, then the
    // controller model reacts at the falling edge.
    task automatic cycle();
        logic busy_seen;
        busy_seen = sd.sdram_isBusy;
        @(negedge clk);
        tick = 1'b0;
        stop = 1'b0;
        if (sd.sdram_recievedCommand) begin
            sd.sdram_recievedCommand = 1'b0;
            chk("gap_after_accept", sd.sdram_inputValid, 0);
            hold_cnt = 0;
        end else if (sd.sdram_inputValid) begin
            if (!prev_valid) chk("valid_while_busy", busy_seen, 0);
            chk("is_writing", sd.sdram_isWriting, 1);
            hold_cnt++;
            if (auto_delay != 0 && hold_cnt >= auto_delay) accept_now();
        end else begin
            hold_cnt = 0;
        end
        prev_valid = sd.sdram_inputValid;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && !complete; i++) cycle();
        chk("complete", complete, 1);
    endtask

    task automatic check_log(input int nw, input int n);
        chk("n_writes", log_d.size(), nw);
        for (int k = 0; k < nw && k < log_d.size(); k++) begin
            chk("write_addr", log_a[k], k);
            chk("write_data", log_d[k], exp_word(k, n));
        end
    endtask

    task automatic run_capture(input int n, input bit use_stop, input int gap);
        log_a.delete();
        log_d.delete();
        ms = 5'd4;
        cycle();
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) cycle();
            tick = 1'b1;
            samp = s[i];
            if (use_stop && i == n - 1) stop = 1'b1;
            cycle();
        end
        tick = 1'b1;
        samp = 8'hFF;
        cycle();
        wait_done();
        check_log((n + 1) / 2, n);
        chk("recorded_words", recw, (n + 1) / 2);
        chk("overrun_zero", ovr, 0);
        chk("dbg_ovr", dbg[31:24], 0);
        chk("dbg_pad", dbg[23:19], 0);
        chk("dbg_rec", dbg[15:0], (n + 1) / 2);
        ms = 5'd0;
        cycle();
        cycle();
        chk("complete_clear", complete, 0);
    endtask

    initial begin
        int n;
        int ticks;
        sd.sdram_recievedCommand = 1'b0;
        sd.sdram_isBusy = 1'b0;
        repeat (3) cycle();
        chk("rst_valid", sd.sdram_inputValid, 0);
        chk("rst_addr", sd.sdram_inputAddress, 0);
        chk("rst_data", sd.sdram_writeData, 0);
        chk("rst_complete", complete, 0);
        chk("rst_rec", recw, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_dbg", dbg, 0);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) s[i] = 8'(8'h11 * (i + 1));
        auto_delay = 3;
        run_capture(6, 1'b0, 20);

        s[0] = 8'hA1; s[1] = 8'hB2; s[2] = 8'hC3;
        run_capture(3, 1'b1, 20);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) s[i] = 8'($urandom);
            run_capture(n, n < 6, $urandom_range(8, 20));
        end

        // SDRAM busy: first word waits in the pending slot, the next two are dropped.
        for (int i = 0; i < 6; i++) s[i] = 8'($urandom);
        log_a.delete();
        log_d.delete();
        sd.sdram_isBusy = 1'b1;
        ms = 5'd4;
        cycle();
        ticks = 0;
        for (int c = 0; c < 100; c++) begin
            if (c % 10 == 5 && ticks < 6) begin
                tick = 1'b1;
                samp = s[ticks];
                ticks++;
            end
            cycle();
            chk("busy_no_valid", sd.sdram_inputValid, 0);
        end
        sd.sdram_isBusy = 1'b0;
        wait_done();
        chk("busy_overruns", ovr, 2);
        chk("busy_recorded", recw, 1);
        check_log(1, 6);
        ms = 5'd0;
        cycle();
        cycle();

        // Word completes on the very edge the pending word is accepted.
        for (int i = 0; i < 6; i++) s[i] = 8'($urandom);
        log_a.delete();
        log_d.delete();
        auto_delay = 0;
        ms = 5'd4;
        cycle();
        tick = 1'b1; samp = s[0]; cycle();
        tick = 1'b1; samp = s[1]; cycle();
        cycle();
        chk("sim_valid0", sd.sdram_inputValid, 1);
        chk("sim_data0", sd.sdram_writeData, exp_word(0, 6));
        chk("sim_addr0", sd.sdram_inputAddress, 0);
        tick = 1'b1; samp = s[2]; cycle();
        tick = 1'b1; samp = s[3];
        accept_now();
        cycle();
        chk("sim_valid_drop", sd.sdram_inputValid, 0);
        chk("sim_no_overrun", ovr, 0);
        cycle();
        chk("sim_valid1", sd.sdram_inputValid, 1);
        chk("sim_data1", sd.sdram_writeData, exp_word(1, 6));
        chk("sim_addr1", sd.sdram_inputAddress, 1);
        auto_delay = 3;
        repeat (5) cycle();
        tick = 1'b1; samp = s[4]; cycle();
        repeat (5) cycle();
        tick = 1'b1; samp = s[5]; cycle();
        wait_done();
        check_log(3, 6);
        chk("sim_recorded", recw, 3);
        chk("sim_ovr_end", ovr, 0);
        ms = 5'd0;
        cycle();
        cycle();

        // Abort in the middle of a handshake, then re-enter from the base address.
        for (int i = 0; i < 6; i++) s[i] = 8'($urandom);
        auto_delay = 0;
        ms = 5'd4;
        cycle();
        tick = 1'b1; samp = s[0]; cycle();
        tick = 1'b1; samp = s[1]; cycle();
        cycle();
        chk("abort_valid_before", sd.sdram_inputValid, 1);
        ms = 5'd0;
        cycle();
        chk("abort_valid_drop", sd.sdram_inputValid, 0);
        chk("abort_complete", complete, 0);
        chk("abort_rec_hold", recw, 0);
        repeat (3) cycle();
        chk("abort_complete_later", complete, 0);
        auto_delay = 3;
        for (int i = 0; i < 6; i++) s[i] = 8'($urandom);
        run_capture(6, 1'b0, 10);

        // Asynchronous reset between clock edges while a command is presented.
        s[0] = 8'h5A; s[1] = 8'hC3; s[2] = 8'h7E; s[3] = 8'h81;
        auto_delay = 3;
        ms = 5'd4;
        cycle();
        for (int i = 0; i < 4; i++) begin
            repeat (9) cycle();
            tick = 1'b1;
            samp = s[i];
            cycle();
        end
        auto_delay = 0;
        cycle();
        chk("rst_pre_valid", sd.sdram_inputValid, 1);
        chk("rst_pre_rec", recw, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", sd.sdram_inputValid, 0);
        chk("arst_writing", sd.sdram_isWriting, 0);
        chk("arst_addr", sd.sdram_inputAddress, 0);
        chk("arst_data", sd.sdram_writeData, 0);
        chk("arst_complete", complete, 0);
        chk("arst_rec", recw, 0);
        chk("arst_ovr", ovr, 0);
        chk("arst_dbg", dbg, 0);
        ms = 5'd0;
        cycle();
        rst = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/music_box_recorder.md
Name: music_box_recorder

Overview:
- Parametrised recording engine for the MakeRecording user-interface state.
- Captures SPI samples on a sample-rate strobe and packs them into SDRAM-width words.
- Writes the words to SDRAM using the full valid/received/busy handshake, with one-word buffering and overrun accounting.
- Stops on a length limit or a user stop, flushes any partial word, then raises stateComplete for MusicBoxStateController.

Parameters:
- SAMPLE_W, 8: width of one audio sample.
- WORD_W, 16: SDRAM data width. Must be a multiple of SAMPLE_W.
- ADDR_W, 25: SDRAM address width.
- BASE_ADDR, 0: first SDRAM word address written.
- MAX_SAMPLES, 441000: recording length limit in samples (20 s at 22050 Hz).
- STATE_ID, 4: mainState value that enables this block.
- PACK_EN, 1: 1 = pack WORD_W/SAMPLE_W samples per word, LSB-first; 0 = one sample per word, zero-extended.

Ports:
- clock_50Mhz, in, 1: system clock. All logic is on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- mainState, in, 5: top-level state. The block is active only while mainState == STATE_ID.
- sample_tick, in, 1: single-cycle strobe at the sample rate, synchronous to clock_50Mhz.
- stop_request, in, 1: single-cycle request to end the recording early.
- SPIinput_sample, in, SAMPLE_W: current sample; sampled on sample_tick.
- sdram_inputAddress, out, ADDR_W: write address.
- sdram_writeData, out, WORD_W: write data.
- sdram_isWriting, out, 1: command is a write.
- sdram_inputValid, out, 1: command request.
- sdram_recievedCommand, in, 1: SDRAM controller accepted the command this cycle.
- sdram_isBusy, in, 1: controller cannot take a new command.
- stateComplete, out, 1: recording finished and all data written.
- recorded_words, out, ADDR_W: number of words committed to SDRAM.
- overrun_count, out, 8: number of words dropped; saturates at 255.
- debugString, out, 32: {overrun_count, 5'b0, state[2:0], recorded_words[15:0]}.

Behaviour:
- Reset (async, active-high) drives every output to 0 and the FSM to IDLE. It also clears the sample counter, the pack register, the pending-word flag and the word address.
- FSM states: IDLE, CAPTURE, FLUSH, DONE.
- IDLE -> CAPTURE when mainState == STATE_ID. On entry: counters = 0, address = BASE_ADDR.
- CAPTURE, on each sample_tick:
  - shift SPIinput_sample into the pack register at lane = sample_count mod (WORD_W/SAMPLE_W);
  - increment sample_count.
  - The word is complete when the last lane fills, or on every tick if PACK_EN = 0.
- Word completion:
  - If no word is pending, the word goes to the pending register and pending is set.
  - If a word is already pending, the new word is dropped, overrun_count increments (saturating), and the address does not advance.
- SDRAM write handshake:
  - When pending = 1 and sdram_isBusy = 0, assert sdram_inputValid = 1 and sdram_isWriting = 1, with address and data taken from the pending word.
  - Hold address, data and valid stable until a cycle with sdram_recievedCommand = 1.
  - On the next cycle: inputValid = 0, pending = 0, address += 1, recorded_words += 1.
  - inputValid is never asserted while isBusy = 1 unless a command is already being presented.
  - Minimum gap between commands is 1 cycle.
- Simultaneous events:
  - Word completion in the same cycle as recievedCommand: the new word enters pending in that same cycle. No overrun is counted.
  - sample_tick in the same cycle as stop_request: the sample is captured, then the block goes to FLUSH.
- CAPTURE -> FLUSH when sample_count reaches MAX_SAMPLES (including the tick that reaches it) or when stop_request = 1. Ticks after this point are ignored.
- FLUSH:
  - If the pack register is partially filled, the empty lanes are zero-padded and the word is queued as a normal word (overrun rules apply).
  - Stay in FLUSH until pending = 0, then go to DONE.
- DONE: stateComplete = 1, held until mainState != STATE_ID, then go to IDLE with stateComplete = 0.
- Abort: if mainState != STATE_ID while in CAPTURE or FLUSH, go to IDLE next cycle.
  - inputValid drops and any pending word is discarded.
  - stateComplete stays 0.
  - recorded_words and overrun_count hold until the next entry to the block.
- Address arithmetic is modulo 2^ADDR_W (wraps, no error).
- A dropped word consumes its samples and does not stall sample capture.

Test Plan:
- Defaults, MAX_SAMPLES = 6, tick every 20 cycles, SDRAM accepts after 3 cycles, samples 0x11..0x66 -> words 0x2211, 0x4433, 0x6655 at addresses 0, 1, 2; recorded_words = 3; stateComplete rises after the third accept.
- PACK_EN = 1, stop_request after 3 samples 0xA1, 0xB2, 0xC3 -> words 0xB2A1 and 0x00C3 (zero-padded); recorded_words = 2; DONE.
- sdram_isBusy held 1 for 100 cycles with a tick every 10 cycles -> inputValid stays 0 while busy; overrun_count increments per dropped word; first write data = first packed word.
- sample_tick completes a word in the same cycle as sdram_recievedCommand -> no overrun; the new word is presented 1 cycle after inputValid drops.
- mainState changes 4 -> 0 mid-handshake -> inputValid = 0 the next cycle, FSM in IDLE, stateComplete = 0; re-entry restarts at BASE_ADDR.
- Async reset asserted mid-CAPTURE between clock edges -> all outputs are 0 immediately.
